loop_start_driver: RTL and testbench

- Initiator side of the start/count loop interface.
- Issues rising edges on `start` toward a countdown-loop responder (combinational or sequential variant) and samples the responder's `count` after a settle window.
- Checks that each edge produced exactly the expected count increment; accumulates pass/fail.
- Sits in regression tops, driving one or more loop responders in place of a hand-written cyc case statement.

---
 rtl/loop_drv_pkg.sv | 15 +
 rtl/loop_start_driver_cycle_timer.sv | 31 +++
 rtl/loop_start_driver.sv | 130 +++++++++++++
 tb/tb_loop_start_driver.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/loop_drv_pkg.sv
// Shared types and constants for the start/count loop initiator.
package loop_drv_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOW    = 3'd1,
        HIGH   = 3'd2,
        SETTLE = 3'd3,
        CHECK  = 3'd4,
        FIN    = 3'd5
    } state_t;

    localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/loop_start_driver_cycle_timer.sv
// Loadable down-counter; expire pulses once when a loaded count reaches zero.
module cycle_timer #(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic [TW-1:0] value,
    output logic          expire
);

    logic running;

    assign expire = running && (value == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            value   <= '0;
            running <= 1'b0;
        end else if (load) begin
            value   <= load_val;
            running <= 1'b1;
        end else if (expire) begin
            running <= 1'b0;
        end else if (running) begin
            value <= value - 1'b1;
        end
    end

endmodule

// File: rtl/loop_start_driver.sv
// Drives start edges into a countdown-loop responder and checks each edge
// produced the expected count increment.
module loop_start_driver
    import loop_drv_pkg::*;
#(
    parameter int CW            = 32,
    parameter int EXP_DELTA     = 3,
    parameter int HOLD_CYCLES   = 1,
    parameter int LOW_CYCLES    = 1,
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_RUNS      = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [CW-1:0] count_in,
    output logic          start,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [7:0]    run_idx,
    output logic [CW-1:0] last_delta,
    output logic [7:0]    err_count
);

    localparam int TW    = 16;
    // start-high phase spans whichever is longer: the hold or the settle window
    localparam int PHASE = (HOLD_CYCLES > SETTLE_CYCLES) ? HOLD_CYCLES : SETTLE_CYCLES;

    localparam logic [TW-1:0] LOW_LD   = TW'(LOW_CYCLES - 1);
    localparam logic [TW-1:0] HI_LD    = TW'(PHASE - 1);
    localparam logic [TW-1:0] DROP_AT  = TW'(PHASE - HOLD_CYCLES);
    localparam logic [7:0]    LAST_RUN = 8'(NUM_RUNS - 1);
    localparam logic [CW-1:0] EXP      = CW'(EXP_DELTA);
    localparam bit            HAS_TAIL = (HOLD_CYCLES < PHASE);

    state_t        state, next_state;
    logic          tmr_load, tmr_exp;
    logic [TW-1:0] tmr_val, tmr_value;
    logic [CW-1:0] base, delta;
    logic [7:0]    err_next;

    cycle_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value),
        .expire   (tmr_exp)
    );

    // modulo-2^CW difference, so a wrapping counter still measures correctly
    assign delta = count_in - base;

    always_comb begin
        err_next = err_count;
        if (state == CHECK && delta != EXP && err_count != ERR_MAX)
            err_next = err_count + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        tmr_load   = 1'b0;
        tmr_val    = LOW_LD;
        case (state)
            IDLE: if (go) begin
                next_state = LOW;
                tmr_load   = 1'b1;
            end
            LOW: if (tmr_exp) begin
                next_state = HIGH;
                tmr_load   = 1'b1;
                tmr_val    = HI_LD;
            end
            HIGH: begin
                if (tmr_exp)
                    next_state = CHECK;
                else if (HAS_TAIL && tmr_value == DROP_AT)
                    next_state = SETTLE;
            end
            SETTLE: if (tmr_exp) next_state = CHECK;
            CHECK: begin
                if (run_idx == LAST_RUN) begin
                    next_state = FIN;
                end else begin
                    next_state = LOW;
                    tmr_load   = 1'b1;
                end
            end
            FIN:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            run_idx    <= 8'd0;
            last_delta <= '0;
            err_count  <= 8'd0;
            base       <= '0;
        end else begin
            start <= (next_state == HIGH);
            busy  <= (next_state inside {LOW, HIGH, SETTLE, CHECK});
            done  <= (next_state == FIN);
            if (state == IDLE && go) begin
                err_count <= 8'd0;
                run_idx   <= 8'd0;
                pass      <= 1'b0;
            end
            if (state == LOW && tmr_exp)
                base <= count_in;
            if (state == CHECK) begin
                last_delta <= delta;
                err_count  <= err_next;
                if (run_idx != LAST_RUN) run_idx <= run_idx + 8'd1;
                else                     pass    <= (err_next == 8'd0);
            end
        end
    end

endmodule

// File: tb/tb_loop_start_driver.sv
// Randomized bench: three driver instances with different settle windows,
// each looped to a behavioural responder, checked against a timeline model.
module tb_loop_start_driver;

    logic        clk = 1'b0;
    logic        rst, go;
    int          sel, inc;
    logic [31:0] off;
    int          vectors = 0, miscompares = 0, cyc = 0;

    logic        start_v [3], busy_v [3], done_v [3], pass_v [3];
    logic [7:0]  run_idx_v [3], err_v [3];
    logic [31:0] delta_v [3], cnt_v [3];

    always #5 clk = ~clk;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        localparam int SET = (i == 0) ? 1 : (i == 1) ? 4 : 2;
        localparam int DLY = (i == 0) ? 1 : 3;
        localparam int PIX = (DLY > 1) ? DLY - 2 : 0;
        logic        go_i;
        logic [31:0] resp  = '0;
        logic        start_d = 1'b0;
        logic [7:0]  pipe  = '0;
        logic        rise;

        assign go_i     = go && (sel == i);
        assign cnt_v[i] = resp + off;
        assign rise     = start_v[i] && !start_d;

        loop_start_driver #(
            .CW(32), .EXP_DELTA(3), .HOLD_CYCLES(1), .LOW_CYCLES(1),
            .SETTLE_CYCLES(SET), .NUM_RUNS(2)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .go         (go_i),
            .count_in   (cnt_v[i]),
            .start      (start_v[i]),
            .busy       (busy_v[i]),
            .done       (done_v[i]),
            .pass       (pass_v[i]),
            .run_idx    (run_idx_v[i]),
            .last_delta (delta_v[i]),
            .err_count  (err_v[i])
        );

        // responder: count moves by inc, DLY cycles after each start rising edge
        always @(posedge clk) begin
            start_d <= start_v[i];
            pipe    <= {pipe[6:0], rise};
            if ((DLY == 1 && rise) || (DLY > 1 && pipe[PIX]))
                resp <= resp + 32'(inc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // count value seen in cycle t, given edges at g+2+k*rl and a DLY-cycle response
    function automatic logic [31:0] cnt_at(int t, logic [31:0] c0, int inc_v, int g, int rl, int dly);
        int n = 0;
        for (int k = 0; k < 2; k++)
            if (g + 2 + k * rl + dly <= t) n++;
        return c0 + 32'(inc_v * n);
    endfunction

    task automatic run_seq(input int s, input int inc_v, input logic [31:0] off_v,
                           input bit mid_go, input bit done_go);
        int ph, dly, rl, g, done_c, edges, dones, got_done, nerr;
        logic [31:0] c0, d, dlast;
        logic prev, es;
        ph  = (s == 0) ? 1 : (s == 1) ? 4 : 2;
        dly = (s == 0) ? 1 : 3;
        rl  = 1 + ph + 1;
        sel = s; inc = inc_v; off = off_v;
        repeat (4) tick();
        c0 = cnt_v[s];
        go = 1'b1; g = cyc;
        tick();
        go = 1'b0;
        done_c = g + 2 * rl + 1;
        nerr = 0; dlast = '0;
        for (int k = 0; k < 2; k++) begin
            d = cnt_at(g + 2 + k * rl + ph, c0, inc_v, g, rl, dly)
              - cnt_at(g + 1 + k * rl, c0, inc_v, g, rl, dly);
            if (d != 32'd3) nerr++;
            dlast = d;
        end
        edges = 0; dones = 0; got_done = -1; prev = 1'b0;
        while (cyc <= done_c + 4) begin
            es = 1'b0;
            for (int k = 0; k < 2; k++)
                if (cyc == g + 2 + k * rl) es = 1'b1;
            chk("start", start_v[s], es);
            if (start_v[s] && !prev) edges++;
            prev = start_v[s];
            if (done_v[s]) begin dones++; got_done = cyc; end
            go = (mid_go && cyc == g + 3) || (done_go && cyc == done_c);
            tick();
        end
        go = 1'b0;
        chk("edges", edges, 2);
        chk("done_count", dones, 1);
        chk("done_cycle", got_done, done_c);
        chk("err_count", err_v[s], nerr);
        chk("pass", pass_v[s], nerr == 0);
        chk("last_delta", delta_v[s], dlast);
        chk("busy_after", busy_v[s], 0);
    endtask

    initial begin
        int g;
        rst = 1'b1; go = 1'b0; sel = 0; inc = 3; off = '0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            chk("rst_start", start_v[i], 0);
            chk("rst_busy", busy_v[i], 0);
            chk("rst_done", done_v[i], 0);
            chk("rst_pass", pass_v[i], 0);
            chk("rst_run_idx", run_idx_v[i], 0);
            chk("rst_err", err_v[i], 0);
            chk("rst_delta", delta_v[i], 0);
        end
        rst = 1'b0;

        run_seq(0, 3, '0, 0, 0);
        run_seq(0, 6, '0, 0, 0);
        run_seq(0, 3, 32'hFFFF_FFFE - g_dut[0].resp, 0, 0);

        // reset on the first HIGH cycle of run 1
        sel = 0; inc = 3;
        repeat (4) tick();
        go = 1'b1; g = cyc;
        tick();
        go = 1'b0;
        while (cyc < g + 5) tick();
        chk("pre_rst_start", start_v[0], 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_start", start_v[0], 0);
        chk("mid_rst_busy", busy_v[0], 0);
        chk("mid_rst_run_idx", run_idx_v[0], 0);
        chk("mid_rst_err", err_v[0], 0);
        chk("mid_rst_done", done_v[0], 0);
        for (int i = 0; i < 8; i++) begin
            chk("post_rst_no_done", done_v[0], 0);
            chk("post_rst_no_start", start_v[0], 0);
            tick();
        end
        run_seq(0, 3, off, 0, 0);

        run_seq(0, 3, off, 1, 1);
        run_seq(1, 3, $urandom, 0, 0);
        run_seq(2, 3, $urandom, 0, 0);

        for (int i = 0; i < 10; i++) begin
            int s, incv;
            s = $urandom_range(0, 2);
            case ($urandom_range(0, 3))
                0: incv = 3;
                1: incv = 6;
                2: incv = 0;
                default: incv = 3;
            endcase
            run_seq(s, incv, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
